// File: rtl/wb_regfile.sv
// Writeback stage: selects the WB result, writes the 32-entry integer register file,
// serves two decode read ports with same-cycle write-through, and counts retired instructions.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validw,
  input  logic            regWrtw,
  input  logic [1:0]      rsltSrcw,
  input  logic [XLEN-1:0] aluRsltw,
  input  logic [XLEN-1:0] readDw,
  input  logic [XLEN-1:0] pc4w,
  input  logic [XLEN-1:0] ujWrtBckw,
  input  logic [4:0]      rdw,
  input  logic [4:0]      rs1d,
  input  logic [4:0]      rs2d,
  output logic [XLEN-1:0] rd1d,
  output logic [XLEN-1:0] rd2d,
  output logic [XLEN-1:0] resultw,
  output logic            wbEnw,
  output logic [CNTW-1:0] instret
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [CNTW-1:0] instret_q;
  logic [CNTW-1:0] instret_d;
  logic            byp_en;

  always_comb begin
    resultw = aluRsltw;
    case (rsltSrcw)
      2'b00:   resultw = aluRsltw;
      2'b01:   resultw = readDw;
      2'b10:   resultw = pc4w;
      2'b11:   resultw = ujWrtBckw;
      default: resultw = aluRsltw;
    endcase
  end

  // rdw != 0 keeps x0 out of both the write path and the bypass path.
  assign wbEnw  = validw & regWrtw & (rdw != 5'd0);
  assign byp_en = wbEnw & ~rst;

  always_comb begin
    regs_d = regs_q;
    if (wbEnw) regs_d[rdw] = resultw;
    regs_d[0] = '0;
  end

  always_comb begin
    instret_d = instret_q;
    if (validw) instret_d = instret_q + 1'b1;
  end

  // Reads are forced to zero while reset is held so a live bypass cannot leak through.
  always_comb begin
    rd1d = '0;
    if (!rst && rs1d != 5'd0) begin
      if (byp_en && rs1d == rdw) rd1d = resultw;
      else                       rd1d = regs_q[rs1d];
    end
  end

  always_comb begin
    rd2d = '0;
    if (!rst && rs2d != 5'd0) begin
      if (byp_en && rs2d == rdw) rd2d = resultw;
      else                       rd2d = regs_q[rs2d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      instret_q <= '0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 4-bit counter exercises counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        validw, regWrtw;
  logic [1:0]  rsltSrcw;
  logic [31:0] aluRsltw, readDw, pc4w, ujWrtBckw;
  logic [4:0]  rdw, rs1d, rs2d;
  logic [31:0] rd1d, rd2d, resultw;
  logic        wbEnw;
  logic [63:0] instret;
  logic [31:0] s_rd1d, s_rd2d, s_resultw;
  logic        s_wbEnw;
  logic [3:0]  s_instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] mux_exp [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

  wb_regfile dut (
    .clk(clk), .rst(rst), .validw(validw), .regWrtw(regWrtw), .rsltSrcw(rsltSrcw),
    .aluRsltw(aluRsltw), .readDw(readDw), .pc4w(pc4w), .ujWrtBckw(ujWrtBckw),
    .rdw(rdw), .rs1d(rs1d), .rs2d(rs2d), .rd1d(rd1d), .rd2d(rd2d),
    .resultw(resultw), .wbEnw(wbEnw), .instret(instret)
  );

  wb_regfile #(.CNTW(4)) dut_small (
    .clk(clk), .rst(rst), .validw(validw), .regWrtw(regWrtw), .rsltSrcw(rsltSrcw),
    .aluRsltw(aluRsltw), .readDw(readDw), .pc4w(pc4w), .ujWrtBckw(ujWrtBckw),
    .rdw(rdw), .rs1d(rs1d), .rs2d(rs2d), .rd1d(s_rd1d), .rd2d(s_rd2d),
    .resultw(s_resultw), .wbEnw(s_wbEnw), .instret(s_instret)
  );

  // clock block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one WB instruction at the falling edge
  task automatic drive(input logic v, input logic w, input logic [1:0] src,
                       input logic [4:0] rd, input logic [31:0] alu);
    @(negedge clk);
    validw   = v;
    regWrtw  = w;
    rsltSrcw = src;
    rdw      = rd;
    aluRsltw = alu;
  endtask

  task automatic edge_then_idle();
    @(posedge clk);
    #1;
    validw = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    validw = 1'b0; regWrtw = 1'b0; rsltSrcw = 2'b00;
    aluRsltw = '0; readDw = 32'hB; pc4w = 32'hC; ujWrtBckw = 32'hD;
    rdw = '0; rs1d = '0; rs2d = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rs1d = 5'd3;
    #1;
    check("reset_rd1d", rd1d, 0);
    check("reset_instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;

    // result mux: write x3 with each source, read back from storage
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, k[1:0], 5'd3, 32'hA);
      rs1d = 5'd3;
      #1;
      check($sformatf("mux_result_%0d", k), resultw, mux_exp[k]);
      edge_then_idle();
      check($sformatf("mux_x3_%0d", k), rd1d, mux_exp[k]);
    end
    check("mux_instret", instret, 4);

    // write-through bypass on both ports
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'hDEADBEEF);
    rs1d = 5'd7; rs2d = 5'd7;
    #1;
    check("byp_wben", wbEnw, 1);
    check("byp_rd1d", rd1d, 32'hDEADBEEF);
    check("byp_rd2d", rd2d, 32'hDEADBEEF);
    edge_then_idle();
    check("byp_store_rd1d", rd1d, 32'hDEADBEEF);
    check("byp_store_rd2d", rd2d, 32'hDEADBEEF);

    // x0 protection
    drive(1'b1, 1'b1, 2'b00, 5'd0, 32'hFFFFFFFF);
    rs1d = 5'd0; rs2d = 5'd0;
    #1;
    check("x0_wben", wbEnw, 0);
    check("x0_rd1d_pre", rd1d, 0);
    edge_then_idle();
    check("x0_rd1d_post", rd1d, 0);
    check("x0_rd2d_post", rd2d, 0);
    check("x0_instret", instret, 6);

    // bubble: no write, no count
    drive(1'b0, 1'b1, 2'b00, 5'd9, 32'h55);
    rs1d = 5'd9;
    #1;
    check("bub_wben", wbEnw, 0);
    check("bub_rd1d_pre", rd1d, 0);
    @(posedge clk);
    #1;
    check("bub_rd1d_post", rd1d, 0);
    check("bub_instret", instret, 6);

    // valid but no register write: counts, does not write
    drive(1'b1, 1'b0, 2'b00, 5'd9, 32'h66);
    edge_then_idle();
    check("nowr_rd1d", rd1d, 0);
    check("nowr_instret", instret, 7);

    // independent ports
    rs1d = 5'd3; rs2d = 5'd7;
    #1;
    check("dual_rd1d", rd1d, 32'hD);
    check("dual_rd2d", rd2d, 32'hDEADBEEF);

    // reset mid-operation
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h12345678);
    rs1d = 5'd5;
    edge_then_idle();
    check("pre_rst_x5", rd1d, 32'h12345678);
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h77);
    #2;
    rst = 1'b1;
    #1;
    check("rst_x5", rd1d, 0);
    check("rst_instret", instret, 0);
    @(posedge clk);
    #1;
    check("rst_held_instret", instret, 0);
    @(negedge clk);
    validw = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_nowrite_x5", rd1d, 0);
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h99);
    edge_then_idle();
    check("post_rst_x5", rd1d, 32'h99);
    check("post_rst_instret", instret, 1);

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, 2'b00, 5'd0, 32'h0);
    end
    edge_then_idle();
    check("wrap_small_14", s_instret, 14);
    drive(1'b1, 1'b1, 2'b00, 5'd10, 32'h1);
    edge_then_idle();
    check("wrap_small_15", s_instret, 15);
    drive(1'b1, 1'b0, 2'b00, 5'd10, 32'h2);
    edge_then_idle();
    check("wrap_small_0", s_instret, 0);
    check("wrap_big_16", instret, 16);
    drive(1'b1, 1'b1, 2'b01, 5'd11, 32'h3);
    edge_then_idle();
    check("wrap_small_1", s_instret, 1);
    check("wrap_big_17", instret, 17);
    rs1d = 5'd10; rs2d = 5'd11;
    #1;
    check("wrap_x10", rd1d, 32'h1);
    check("wrap_x11", rd2d, 32'hB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. Selects the writeback result and writes it into a 32x32 integer register file. Serves the decode stage's two read ports with same-cycle write-through bypass, and exposes the result for EX-stage forwarding. Also keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers (x0 hardwired to zero)
CNTW, 64, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
validw  input  1  WB slot holds a real instruction (0 = bubble)
regWrtw  input  1  instruction writes rd
rsltSrcw  input  2  result select: 00 aluRsltw, 01 readDw, 10 pc4w, 11 ujWrtBckw
aluRsltw  input  XLEN  ALU result
readDw  input  XLEN  load data
pc4w  input  XLEN  PC+4 (link value)
ujWrtBckw  input  XLEN  LUI/AUIPC writeback value
rdw  input  5  destination register index
rs1d  input  5  decode read index 1
rs2d  input  5  decode read index 2
rd1d  output  XLEN  read data 1
rd2d  output  XLEN  read data 2
resultw  output  XLEN  selected WB result, for forwarding
wbEnw  output  1  effective write enable this cycle, for forwarding/hazard logic
instret  output  CNTW  retired-instruction count

Behaviour:
- Reset (async, active-high): all NREG registers cleared to 0; instret = 0. While rst is high, no writes and no counting. rd1d/rd2d read 0 during reset. Reset deasserting mid-stream discards the in-flight WB instruction; the first edge after release operates normally.
- Result mux (combinational): resultw = mux(rsltSrcw) over the four inputs, per the encoding above. resultw is driven even when validw=0; consumers qualify it with wbEnw.
- wbEnw = validw & regWrtw & (rdw != 0). Combinational.
- Write: on rising clk, if wbEnw, reg[rdw] <= resultw. Single write port; latency 1 edge.
- x0: never written (blocked by wbEnw); reading index 0 returns 0 always, including when bypass matches.
- Read (combinational, 0-cycle):
  - rd1d = (rs1d==0) ? 0 : (wbEnw & rs1d==rdw) ? resultw : reg[rs1d].
  - rd2d uses the same rule with rs2d.
  - Write-through bypass: decode sees the value being written in the same cycle.
  - Both ports may hit the same register or the same bypass simultaneously; both return identical data.
- Bubble (validw=0): no write, no count, regardless of regWrtw and rdw.
- instret: on rising clk, if validw, instret <= instret + 1. Wraps modulo 2^CNTW to 0, no saturation. Counting is independent of regWrtw (stores and branches retire too).
- No backpressure: WB always completes in one cycle; stalls are expressed upstream as validw=0.
- Unknown/X on rsltSrcw while validw=0 must not corrupt state.

Test Plan:
- Reset mid-operation: preload x5=0x12345678, assert rst asynchronously between edges -> x5 reads 0 immediately; instret=0; no write on the next edge while rst is high.
- Mux select: rdw=3, validw=1, regWrtw=1, aluRsltw=0xA, readDw=0xB, pc4w=0xC, ujWrtBckw=0xD; step rsltSrcw 00..11 over four cycles -> x3 reads 0xA, 0xB, 0xC, 0xD in turn, each one cycle after its write.
- Bypass: write x7=0xDEADBEEF with rs1d=rs2d=7 in the same cycle -> rd1d=rd2d=0xDEADBEEF combinationally, before the edge; after the edge both still read 0xDEADBEEF from storage.
- x0 protection: rdw=0, regWrtw=1, validw=1, aluRsltw=0xFFFFFFFF, rs1d=0 -> wbEnw=0, rd1d=0 before and after the edge.
- Bubble: validw=0, regWrtw=1, rdw=9, result 0x55 -> x9 unchanged, wbEnw=0, instret unchanged.
- Counter wrap: force instret to 0xFFFF_FFFF_FFFF_FFFE, then retire 3 valid instructions (one with regWrtw=0) -> instret reads ...FFFF, then 0, then 1.
